// File: rtl/nexys_starship_pkg.sv
// Shared constants for the starship monster controller: one-hot game states,
// blanking length and terminal IDs.
package nexys_starship_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'b001;
   localparam state_t ST_PLAY = 3'b010;
   localparam state_t ST_OVER = 3'b100;

   localparam int unsigned BLANK_CYCLES = 2;

   localparam int unsigned TERM_BTM   = 0;
   localparam int unsigned TERM_TOP   = 1;
   localparam int unsigned TERM_LEFT  = 2;
   localparam int unsigned TERM_RIGHT = 3;

endpackage

// File: rtl/nexys_starship_if.sv
// Game-side signal bundle between the terminal logic and the shared monster controller.
interface nexys_starship_if #(
   parameter int unsigned NUM_TERM = 4,
   parameter int unsigned SCORE_W  = 8
);
   localparam int unsigned AIM_W = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;

   logic                timer_tick;
   logic                play_flag;
   logic                restart;
   logic                shoot;
   logic [AIM_W-1:0]    aim;
   logic [NUM_TERM-1:0] monster_sm;
   logic [NUM_TERM-1:0] term_gameover;
   logic [NUM_TERM-1:0] monster_ctrl;
   logic                gameover_ctrl;
   logic [SCORE_W-1:0]  score;
   logic                hit_pulse;
   logic                miss_pulse;
   logic                q_Idle;
   logic                q_Play;
   logic                q_Over;

   modport master (
      output timer_tick, play_flag, restart, shoot, aim, monster_sm, term_gameover,
      input  monster_ctrl, gameover_ctrl, score, hit_pulse, miss_pulse, q_Idle, q_Play, q_Over
   );

   modport slave (
      input  timer_tick, play_flag, restart, shoot, aim, monster_sm, term_gameover,
      output monster_ctrl, gameover_ctrl, score, hit_pulse, miss_pulse, q_Idle, q_Play, q_Over
   );

endinterface

// File: rtl/nexys_starship_cooldown.sv
// Loadable down-counter with tick enable; stops at zero and flags it.
module nexys_starship_cooldown #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/nexys_starship_ctrl.sv
// Shared monster controller: adopts terminal monsters, resolves shots, keeps score,
// locks the weapon after a miss and owns the IDLE/PLAY/OVER game state.
module nexys_starship_ctrl
   import nexys_starship_pkg::*;
#(
   parameter int unsigned NUM_TERM = 4,
   parameter int unsigned COOLDOWN = 3,
   parameter int unsigned SCORE_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   nexys_starship_if.slave  bus
);

   localparam int unsigned CD_W    = $clog2(COOLDOWN + 1);
   localparam int unsigned BLANK_W = $clog2(BLANK_CYCLES + 1);

   state_t              state_q, state_d;
   logic [NUM_TERM-1:0] monster_ctrl_q, monster_ctrl_d;
   logic                gameover_q, gameover_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic                hit_q, hit_d;
   logic                miss_q, miss_d;

   logic                in_play;
   logic                any_go;
   logic                accept;
   logic                hit;
   logic                miss;
   logic                cd_zero;
   logic                cd_clr;
   logic [NUM_TERM-1:0] hit_vec;
   logic [NUM_TERM-1:0] blank_zero;

   assign in_play = (state_q == ST_PLAY);
   assign any_go  = |bus.term_gameover;
   // A gameover in the same cycle suppresses the shot entirely.
   assign accept  = in_play & bus.shoot & cd_zero & ~any_go;

   // Out-of-range aim matches no terminal and so resolves as a miss.
   always_comb begin
      hit_vec = '0;
      for (int unsigned i = 0; i < NUM_TERM; i++) begin
         hit_vec[i] = accept && (32'(bus.aim) == i) && monster_ctrl_q[i];
      end
   end

   assign hit    = |hit_vec;
   assign miss   = accept & ~hit;
   assign cd_clr = (state_q == ST_OVER) & bus.restart;

   nexys_starship_cooldown #(
      .W (CD_W)
   ) u_weapon_cd (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (cd_clr),
      .load     (miss),
      .load_val (CD_W'(COOLDOWN)),
      .tick     (bus.timer_tick),
      .zero     (cd_zero)
   );

   // Blanking hides a terminal's stale monster_sm right after a kill.
   for (genvar g = 0; g < NUM_TERM; g++) begin : g_blank
      nexys_starship_cooldown #(
         .W (BLANK_W)
      ) u_blank (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (1'b0),
         .load     (hit_vec[g]),
         .load_val (BLANK_W'(BLANK_CYCLES)),
         .tick     (1'b1),
         .zero     (blank_zero[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.play_flag) state_d = ST_PLAY;
         ST_PLAY: if (any_go)        state_d = ST_OVER;
         ST_OVER: if (bus.restart)   state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      monster_ctrl_d = '0;
      gameover_d     = 1'b0;
      score_d        = score_q;
      hit_d          = 1'b0;
      miss_d         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.play_flag) score_d = '0;
         end
         ST_PLAY: begin
            if (any_go) begin
               gameover_d = 1'b1;
            end else begin
               for (int unsigned i = 0; i < NUM_TERM; i++) begin
                  monster_ctrl_d[i] = hit_vec[i] ? 1'b0 :
                                      (monster_ctrl_q[i] | (bus.monster_sm[i] & blank_zero[i]));
               end
               hit_d  = hit;
               miss_d = miss;
               if (hit && (score_q != '1)) score_d = score_q + SCORE_W'(1);
            end
         end
         ST_OVER: begin
            gameover_d = ~bus.restart;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         monster_ctrl_q <= '0;
         gameover_q     <= 1'b0;
         score_q        <= '0;
         hit_q          <= 1'b0;
         miss_q         <= 1'b0;
      end else begin
         monster_ctrl_q <= monster_ctrl_d;
         gameover_q     <= gameover_d;
         score_q        <= score_d;
         hit_q          <= hit_d;
         miss_q         <= miss_d;
      end
   end

   assign bus.monster_ctrl  = monster_ctrl_q;
   assign bus.gameover_ctrl = gameover_q;
   assign bus.score         = score_q;
   assign bus.hit_pulse     = hit_q;
   assign bus.miss_pulse    = miss_q;
   assign bus.q_Idle        = state_q[0];
   assign bus.q_Play        = state_q[1];
   assign bus.q_Over        = state_q[2];

endmodule

// File: tb/tb_nexys_starship_ctrl.sv
// Directed bench: shots push expected pulses into a queue that a negedge monitor drains.
module tb_nexys_starship_ctrl;

   logic clk;
   logic rst_n;

   nexys_starship_if #(.NUM_TERM(4), .SCORE_W(8)) bus ();

   nexys_starship_ctrl #(
      .NUM_TERM (4),
      .COOLDOWN (3),
      .SCORE_W  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit         is_hit;
      logic [7:0] score;
   } pulse_t;

   pulse_t exp_q[$];
   pulse_t mon_e;
   int     n_vec = 0;
   int     n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] status();
      return {bus.q_Idle, bus.q_Play, bus.q_Over, bus.gameover_ctrl, bus.monster_ctrl};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One shot; an expected pulse is queued only when the shot should be accepted.
   task automatic fire(input int t, input bit accepted, input bit is_hit, input int score);
      pulse_t p;
      bus.aim   = t[1:0];
      bus.shoot = 1'b1;
      if (accepted) begin
         p.is_hit = is_hit;
         p.score  = score[7:0];
         exp_q.push_back(p);
      end
      step();
      bus.shoot = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bus.hit_pulse || bus.miss_pulse) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pulse_unexpected: got hit=%0b miss=%0b score=%0d, required no pulse",
                     bus.hit_pulse, bus.miss_pulse, bus.score);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.hit_pulse, bus.miss_pulse} !== {mon_e.is_hit, !mon_e.is_hit} ||
                bus.score !== mon_e.score) begin
               n_bad++;
               $display("FAIL pulse: got hit=%0b miss=%0b score=%0d, required hit=%0b miss=%0b score=%0d",
                        bus.hit_pulse, bus.miss_pulse, bus.score,
                        mon_e.is_hit, !mon_e.is_hit, mon_e.score);
            end
         end
      end
   end

   initial begin
      rst_n             = 1'b0;
      bus.timer_tick    = 1'b0;
      bus.play_flag     = 1'b0;
      bus.restart       = 1'b0;
      bus.shoot         = 1'b0;
      bus.aim           = '0;
      bus.monster_sm    = '0;
      bus.term_gameover = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("reset_status", 32'(status()), 32'h80);
      chk("reset_score", 32'(bus.score), 32'd0);

      // IDLE keeps monster_ctrl low even with a monster present
      bus.monster_sm = 4'b0010;
      step();
      chk("idle_forces_ctrl", 32'(status()), 32'h80);

      bus.monster_sm = 4'b0000;
      bus.play_flag  = 1'b1;
      step();
      bus.play_flag = 1'b0;
      chk("enter_play", 32'(status()), 32'h40);

      bus.monster_sm = 4'b0001;
      #1 chk("adopt_not_comb", 32'(bus.monster_ctrl), 32'h0);
      step();
      chk("adopt_one_edge", 32'(bus.monster_ctrl), 32'h1);

      // Hit with monster_sm lagging high: blanked two cycles, re-adopted on the third
      fire(0, 1'b1, 1'b1, 1);
      chk("hit_clears_ctrl", 32'(bus.monster_ctrl), 32'h0);
      chk("hit_score", 32'(bus.score), 32'd1);
      step();
      chk("blank_cycle1", 32'(bus.monster_ctrl), 32'h0);
      step();
      chk("blank_cycle2", 32'(bus.monster_ctrl), 32'h0);
      step();
      chk("readopt", 32'(bus.monster_ctrl), 32'h1);

      // Miss locks the weapon for three timer ticks
      fire(1, 1'b1, 1'b0, 1);
      for (int k = 0; k < 3; k++) begin
         fire(0, 1'b0, 1'b0, 0);
         bus.timer_tick = 1'b1;
         step();
         bus.timer_tick = 1'b0;
      end
      chk("cooldown_no_score", 32'(bus.score), 32'd1);
      fire(0, 1'b1, 1'b1, 2);
      bus.monster_sm = 4'b0100;
      step();
      chk("adopt_left", 32'(status()), 32'h44);

      // Gameover beats a simultaneous hit
      bus.term_gameover = 4'b0100;
      fire(2, 1'b0, 1'b0, 0);
      bus.term_gameover = 4'b0000;
      chk("gameover_status", 32'(status()), 32'h30);
      chk("gameover_score", 32'(bus.score), 32'd2);
      fire(2, 1'b0, 1'b0, 0);
      bus.play_flag = 1'b1;
      step();
      bus.play_flag = 1'b0;
      chk("over_holds", 32'(status()), 32'h30);
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      chk("restart_idle", 32'(status()), 32'h80);
      chk("idle_keeps_score", 32'(bus.score), 32'd2);

      // Build score 7 with monsters on bottom and left, then reset asynchronously
      bus.monster_sm = 4'b0101;
      bus.play_flag  = 1'b1;
      step();
      bus.play_flag = 1'b0;
      chk("replay_score_cleared", 32'(bus.score), 32'd0);
      step();
      chk("adopt_two", 32'(bus.monster_ctrl), 32'h5);
      for (int n = 0; n < 7; n++) begin
         fire((n % 2 == 1) ? 2 : 0, 1'b1, 1'b1, n + 1);
         repeat (3) step();
      end
      chk("pre_reset_status", 32'(status()), 32'h45);
      chk("pre_reset_score", 32'(bus.score), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_status", 32'(status()), 32'h80);
      chk("async_reset_score", 32'(bus.score), 32'd0);
      chk("async_reset_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Saturation: 256 hits rotating over all terminals
      bus.monster_sm = 4'b1111;
      bus.play_flag  = 1'b1;
      step();
      bus.play_flag = 1'b0;
      step();
      chk("adopt_all", 32'(bus.monster_ctrl), 32'hF);
      for (int n = 0; n < 256; n++) begin
         fire(n % 4, 1'b1, 1'b1, (n + 1 > 255) ? 255 : n + 1);
      end
      repeat (3) step();
      chk("score_saturated", 32'(bus.score), 32'd255);

      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pulses_missing: got %0d pending, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
